// File: rtl/prm_oblgc_engine.sv
// Programmable obstacle-check engine: NCH runtime-loaded truth-table bitmaps looked up
// per sample code, hits OR-accumulated into one blocked-channel mask per PRM edge.
module prm_oblgc_engine #(
    parameter int IN_W  = 15,
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [IN_W-6:0]                          cfg_addr,
    input  logic [31:0]                              cfg_wdata,
    input  logic                                     cfg_clr,
    input  logic [NCH-1:0]                           ch_en,
    output logic                                     busy,
    output logic                                     cfg_err,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    input  logic [IN_W-1:0]                          s_code,
    input  logic                                     s_last,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [NCH-1:0]                           m_mask,
    output logic [CNT_W-1:0]                         m_nsamp,
    output logic [CNT_W-1:0]                         m_hit_idx
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW    = IN_W - 5;
    localparam int WORDS = 1 << AW;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, HOLD, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [NCH-1:0]   en_q, en_d, acc_q, acc_d, m_mask_q, m_mask_d;
    logic [CNT_W-1:0] nsamp_q, nsamp_d, hit_idx_q, hit_idx_d, lk_idx_q, lk_idx_d;
    logic [CNT_W-1:0] m_nsamp_q, m_nsamp_d, m_hit_idx_q, m_hit_idx_d;
    logic             hit_found_q, hit_found_d, lk_vld_q, lk_vld_d, cfg_err_q, cfg_err_d;
    logic [4:0]       bit_q, bit_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d, wr_addr;
    logic [31:0]      wr_data;
    logic             s_fire, ram_clr, cfg_wr;
    logic [NCH-1:0]   look_bits, hits;

    // cfg_clr wins in IDLE, so a sample offered alongside it is not taken
    assign s_ready = !rst && ((state_q == IDLE && !cfg_clr) || state_q == ACCUM);
    assign s_fire  = s_valid && s_ready;
    assign ram_clr = !rst && (state_q == CLEAR);
    assign cfg_wr  = !rst && (state_q == IDLE) && cfg_we && !cfg_clr;
    assign wr_addr = ram_clr ? clr_cnt_q : cfg_addr;
    assign wr_data = ram_clr ? 32'd0 : cfg_wdata;

    // Read-before-write RAM: a same-cycle write/lookup to one word returns old data
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [31:0] mem [WORDS];
        logic [31:0] rd_q;
        logic        we;
        assign we = ram_clr || (cfg_wr && (cfg_ch == CH_W'(c)));
        always_ff @(posedge clk) begin
            if (we) mem[wr_addr] <= wr_data;
            rd_q <= mem[s_code[IN_W-1:5]];
        end
        assign look_bits[c] = rd_q[bit_q];
    end

    assign hits = look_bits & en_q;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        acc_d       = acc_q;
        nsamp_d     = nsamp_q;
        hit_idx_d   = hit_idx_q;
        hit_found_d = hit_found_q;
        lk_vld_d    = 1'b0;
        lk_idx_d    = lk_idx_q;
        bit_d       = s_code[4:0];
        clr_cnt_d   = clr_cnt_q;
        m_mask_d    = m_mask_q;
        m_nsamp_d   = m_nsamp_q;
        m_hit_idx_d = m_hit_idx_q;
        cfg_err_d   = ((cfg_we || cfg_clr) && state_q != IDLE) ||
                      (cfg_we && cfg_clr && state_q == IDLE);

        // Fold the lookup issued by last cycle's accepted sample
        if (lk_vld_q) begin
            acc_d = acc_q | hits;
            if (|hits && !hit_found_q) begin
                hit_found_d = 1'b1;
                hit_idx_d   = lk_idx_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_clr) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (s_fire) begin
                    en_d        = ch_en;
                    acc_d       = '0;
                    nsamp_d     = CNT_W'(1);
                    hit_idx_d   = '1;
                    hit_found_d = 1'b0;
                    lk_vld_d    = 1'b1;
                    lk_idx_d    = '0;
                    state_d     = s_last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (s_fire) begin
                    if (nsamp_q != '1) nsamp_d = nsamp_q + CNT_W'(1);
                    lk_vld_d = 1'b1;
                    lk_idx_d = nsamp_q;
                    if (s_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                m_mask_d    = acc_d;
                m_nsamp_d   = nsamp_q;
                m_hit_idx_d = hit_idx_d;
                state_d     = HOLD;
            end
            HOLD: begin
                if (m_ready) state_d = IDLE;
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(WORDS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= '0;
            acc_q       <= '0;
            nsamp_q     <= '0;
            hit_idx_q   <= '1;
            hit_found_q <= 1'b0;
            lk_vld_q    <= 1'b0;
            lk_idx_q    <= '0;
            bit_q       <= '0;
            clr_cnt_q   <= '0;
            cfg_err_q   <= 1'b0;
            m_mask_q    <= '0;
            m_nsamp_q   <= '0;
            m_hit_idx_q <= '1;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            acc_q       <= acc_d;
            nsamp_q     <= nsamp_d;
            hit_idx_q   <= hit_idx_d;
            hit_found_q <= hit_found_d;
            lk_vld_q    <= lk_vld_d;
            lk_idx_q    <= lk_idx_d;
            bit_q       <= bit_d;
            clr_cnt_q   <= clr_cnt_d;
            cfg_err_q   <= cfg_err_d;
            m_mask_q    <= m_mask_d;
            m_nsamp_q   <= m_nsamp_d;
            m_hit_idx_q <= m_hit_idx_d;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign m_valid   = (state_q == HOLD);
    assign cfg_err   = cfg_err_q;
    assign m_mask    = m_mask_q;
    assign m_nsamp   = m_nsamp_q;
    assign m_hit_idx = m_hit_idx_q;
endmodule

// File: tb/tb_prm_oblgc_engine.sv
// Scoreboard bench for prm_oblgc_engine: expected edge results come from a bit-level
// table model and are checked by a separate monitor when the DUT presents them.
module tb_prm_oblgc_engine;
    localparam int IN_W  = 15;
    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int CH_W  = 2;

    logic             clk, rst, cfg_we, cfg_clr, busy, cfg_err;
    logic [CH_W-1:0]  cfg_ch;
    logic [IN_W-6:0]  cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [NCH-1:0]   ch_en, m_mask;
    logic             s_valid, s_ready, s_last, m_valid, m_ready;
    logic [IN_W-1:0]  s_code;
    logic [CNT_W-1:0] m_nsamp, m_hit_idx;

    prm_oblgc_engine #(.IN_W(IN_W), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_clr(cfg_clr), .ch_en(ch_en), .busy(busy),
        .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask),
        .m_nsamp(m_nsamp), .m_hit_idx(m_hit_idx)
    );

    typedef struct {
        logic [NCH-1:0]   mask;
        logic [CNT_W-1:0] nsamp;
        logic [CNT_W-1:0] hit;
        int               vcyc;
    } exp_t;

    exp_t            sb[$];
    logic [IN_W-1:0] codes[$];
    bit              tbl [NCH][1 << IN_W];
    logic [9:0]      pool [8];
    int              n_chk = 0, n_fail = 0, cyc = 0;
    bit              rdy_force = 1'b1, rdy_val = 1'b1, mv_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // m_ready: random backpressure unless a directed test pins it
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every cycle a result is presented it must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_m_valid", 1, 0);
            end else begin
                if (!mv_seen) chk("result_latency", cyc, sb[0].vcyc);
                chk("m_mask", m_mask, sb[0].mask);
                chk("m_nsamp", m_nsamp, sb[0].nsamp);
                chk("m_hit_idx", m_hit_idx, sb[0].hit);
                if (m_ready) void'(sb.pop_front());
            end
            mv_seen = !m_ready;
        end else begin
            mv_seen = 1'b0;
        end
    end

    task automatic mdl_wr(input int ch, input int addr, input logic [31:0] d);
        for (int b = 0; b < 32; b++) tbl[ch][addr * 32 + b] = d[b];
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 3000);
        if (!s_ready) chk("wait_idle_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_accept(output int acyc);
        int n = 0;
        acyc = -1;
        while (n < 300) begin
            @(negedge clk);
            if (s_ready) begin
                acyc = cyc;
                break;
            end
            n++;
        end
        if (acyc < 0) chk("accept_timeout", 0, 1);
        tick();
    endtask

    task automatic wr(input int ch, input int addr, input logic [31:0] d);
        wait_idle();
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_addr = 10'(addr); cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        mdl_wr(ch, addr, d);
    endtask

    task automatic do_clear();
        int n = 0;
        wait_idle();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("clear_busy_cycles", n, 1024);
        chk("s_ready_after_clear", s_ready, 1);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < (1 << IN_W); k++) tbl[c][k] = 1'b0;
        tick();
    endtask

    // Streams `codes` as one edge; the expected result follows the table rules directly
    task automatic send_edge(input logic [NCH-1:0] en, input int gap, input bit wr_en,
                             input int wch, input int waddr, input logic [31:0] wdata,
                             output int acyc);
        exp_t           e;
        bit             found = 1'b0;
        logic [NCH-1:0] h;
        e.mask = '0; e.nsamp = '0; e.hit = '1; acyc = -1;
        for (int i = 0; i < codes.size(); i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1; s_code = codes[i]; s_last = (i == codes.size() - 1);
            if (i == 0) begin
                ch_en = en;
                if (wr_en) begin
                    cfg_we = 1'b1; cfg_ch = CH_W'(wch); cfg_addr = 10'(waddr); cfg_wdata = wdata;
                end
            end
            wait_accept(acyc);
            cfg_we = 1'b0;
            ch_en  = NCH'($urandom);
            for (int c = 0; c < NCH; c++) h[c] = tbl[c][codes[i]] & en[c];
            e.mask = e.mask | h;
            if (e.nsamp != '1) e.nsamp = e.nsamp + 1'b1;
            if (h != '0 && !found) begin
                found = 1'b1;
                e.hit = CNT_W'(i);
            end
            if (i == 0 && wr_en) mdl_wr(wch, waddr, wdata);
        end
        s_valid = 1'b0; s_last = 1'b0;
        e.vcyc = acyc + 2;
        sb.push_back(e);
    endtask

    task automatic rand_edge();
        int a;
        codes.delete();
        repeat ($urandom_range(1, 8)) begin
            if ($urandom_range(0, 9) != 0) codes.push_back({pool[$urandom_range(0, 7)], 5'($urandom)});
            else codes.push_back(IN_W'($urandom));
        end
        send_edge(NCH'($urandom), 30, 1'b0, 0, 0, 32'd0, a);
    endtask

    initial begin
        int a, n;
        rst = 1'b1; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        ch_en = '0; s_valid = 1'b0; s_code = '0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("s_ready_during_rst", s_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_mask", m_mask, 0);
        chk("rst_m_nsamp", m_nsamp, 0);
        chk("rst_m_hit_idx", m_hit_idx, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_s_ready", s_ready, 1);
        tick();

        do_clear();
        wr(0, 10'h3FF, 32'h0000_0001);
        codes.delete(); codes.push_back(15'h0001); codes.push_back(15'h7FE0); codes.push_back(15'h1234);
        send_edge(4'hF, 0, 1'b0, 0, 0, 32'd0, a);
        @(negedge clk); chk("s_ready_in_drain", s_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("m_valid_one_cycle", m_valid, 0);
        chk("s_ready_at_t3", s_ready, 1);
        tick();
        send_edge(4'hE, 0, 1'b0, 0, 0, 32'd0, a);

        // Backpressure in HOLD plus a config write that must be dropped
        wr(2, 0, 32'h0000_0020);
        rdy_val = 1'b0;
        codes.delete(); codes.push_back(15'h0005);
        send_edge(4'hF, 0, 1'b0, 0, 0, 32'd0, a);
        tick();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 10'h3FF; cfg_wdata = 32'd0;
        @(negedge clk);
        chk("hold_m_valid", m_valid, 1);
        chk("hold_s_ready_0", s_ready, 0);
        chk("cfg_err_same_cycle", cfg_err, 0);
        tick();
        cfg_we = 1'b0;
        @(negedge clk); chk("cfg_err_pulse", cfg_err, 1); chk("hold_s_ready_1", s_ready, 0);
        tick();
        @(negedge clk); chk("cfg_err_cleared", cfg_err, 0); chk("hold_s_ready_2", s_ready, 0);
        tick(); @(negedge clk); chk("hold_s_ready_3", s_ready, 0);
        tick(); @(negedge clk); chk("hold_s_ready_4", s_ready, 0);
        rdy_val = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid && m_ready) && n < 20);
        @(negedge clk);
        chk("s_ready_after_handshake", s_ready, 1);
        chk("m_valid_after_handshake", m_valid, 0);
        tick();
        codes.delete(); codes.push_back(15'h7FE0);
        send_edge(4'hF, 0, 1'b0, 0, 0, 32'd0, a);

        // Write then lookup next cycle (new data), and same cycle (old data)
        wr(1, 10'h155, 32'h0000_0008);
        codes.delete(); codes.push_back(15'h2AA3);
        send_edge(4'hF, 0, 1'b0, 0, 0, 32'd0, a);
        wait_idle();
        codes.delete(); codes.push_back(15'h1547);
        send_edge(4'hF, 0, 1'b1, 3, 10'h0AA, 32'h0000_0080, a);
        send_edge(4'hF, 0, 1'b0, 0, 0, 32'd0, a);

        do_clear();
        codes.delete();
        codes.push_back(15'h7FE0); codes.push_back(15'h0005); codes.push_back(15'h2AA3); codes.push_back(15'h1547);
        send_edge(4'hF, 0, 1'b0, 0, 0, 32'd0, a);

        // Randomised edges over a small pool of populated words
        rdy_force = 1'b0;
        for (int k = 0; k < 8; k++) pool[k] = 10'($urandom);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 8; k++) wr(c, pool[k], $urandom);
        repeat (40) begin
            if ($urandom_range(0, 4) == 0) wr($urandom_range(0, NCH - 1), pool[$urandom_range(0, 7)], $urandom);
            rand_edge();
        end

        // Reset partway through a long edge: nothing may be emitted
        wait_idle();
        ch_en = 4'hF;
        for (int i = 0; i < 50; i++) begin
            s_valid = 1'b1; s_code = {pool[$urandom_range(0, 7)], 5'($urandom)}; s_last = 1'b0;
            wait_accept(a);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_mid_rst", s_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_m_mask", m_mask, 0);
        chk("abort_m_nsamp", m_nsamp, 0);
        chk("abort_m_hit_idx", m_hit_idx, 16'hFFFF);
        chk("abort_busy", busy, 0);
        chk("abort_cfg_err", cfg_err, 0);
        chk("abort_s_ready", s_ready, 1);
        repeat (20) begin
            @(negedge clk);
            chk("no_result_after_abort", m_valid, 0);
        end
        tick();
        repeat (8) rand_edge();

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
